// File: rtl/spike_train_gen_pkg.sv
// Shared definitions for the spike train generator: state encoding, default
// widths and the request clamp.
package spike_train_gen_pkg;

    localparam int unsigned CNT_W_DEF    = 32;
    localparam int unsigned SLOT_W_DEF   = 16;
    localparam int unsigned CLAMP_CNT_W  = 64;
    localparam int unsigned CLAMP_SLOT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Clamp a requested count to the number of available slots; sized wide
    // enough that callers only zero-extend into it.
    function automatic logic [CLAMP_SLOT_W-1:0] min_cnt(
        input logic [CLAMP_CNT_W-1:0]  cnt,
        input logic [CLAMP_SLOT_W-1:0] slots
    );
        if (cnt > CLAMP_CNT_W'(slots)) begin
            return slots;
        end
        return CLAMP_SLOT_W'(cnt);
    endfunction

endpackage

// File: rtl/spike_train_gen_acc.sv
// Bresenham-style rate accumulator: adds N per step and fires whenever the
// running sum reaches M, which spreads N fires evenly over M steps.
module spike_bresenham_acc #(
    parameter int unsigned SLOT_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            step,
    input  logic [SLOT_W:0] n,
    input  logic [SLOT_W:0] m,
    output logic            fire_c
);

    logic [SLOT_W:0] acc_q;
    logic [SLOT_W:0] acc_d;
    logic [SLOT_W:0] sum;

    // acc < M and N <= M, so the sum always fits in SLOT_W+1 bits
    always_comb begin
        sum    = acc_q + n;
        fire_c = step && (sum >= m);
        acc_d  = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (step) begin
            acc_d = fire_c ? (sum - m) : sum;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/spike_train_gen.sv
// Rate-to-spike encoder: emits the requested number of single-cycle spikes per
// frame, evenly spaced across the frame's neuron ticks.
module spike_train_gen
    import spike_train_gen_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned SLOT_W = SLOT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              frame_start,
    input  logic [CNT_W-1:0]  i_cnt,
    input  logic [SLOT_W-1:0] slots,
    output logic              spike,
    output logic [CNT_W-1:0]  spike_cnt_out,
    output logic              frame_done,
    output logic              sat,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [SLOT_W:0]   m_q, m_d;
    logic [SLOT_W:0]   n_q, n_d;
    logic [SLOT_W-1:0] slot_idx_q, slot_idx_d;
    logic [SLOT_W:0]   emitted_q, emitted_d;
    logic              spike_d, frame_done_d, sat_d, busy_d;
    logic [CNT_W-1:0]  cnt_out_d;
    logic              acc_clear, acc_step, fire_c;

    spike_bresenham_acc #(
        .SLOT_W (SLOT_W)
    ) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (acc_clear),
        .step    (acc_step),
        .n       (n_q),
        .m       (m_q),
        .fire_c  (fire_c)
    );

    // Next-state and output logic; frame_start outranks any same-cycle tick
    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        n_d          = n_q;
        slot_idx_d   = slot_idx_q;
        emitted_d    = emitted_q;
        spike_d      = 1'b0;
        frame_done_d = 1'b0;
        cnt_out_d    = spike_cnt_out;
        sat_d        = sat;
        acc_clear    = 1'b0;
        acc_step     = 1'b0;

        if (frame_start) begin
            m_d        = {1'b0, slots};
            n_d        = (SLOT_W+1)'(min_cnt(CLAMP_CNT_W'(i_cnt), CLAMP_SLOT_W'(slots)));
            sat_d      = CLAMP_CNT_W'(i_cnt) > CLAMP_CNT_W'(slots);
            acc_clear  = 1'b1;
            slot_idx_d = '0;
            emitted_d  = '0;
            state_d    = (slots == '0) ? IDLE : RUN;
            if (state_q == RUN) begin
                cnt_out_d    = CNT_W'(emitted_q);
                frame_done_d = 1'b1;
            end else if (slots == '0) begin
                cnt_out_d    = '0;
                frame_done_d = 1'b1;
            end
        end else if (state_q == RUN && tick) begin
            acc_step   = 1'b1;
            slot_idx_d = slot_idx_q + 1'b1;
            if (fire_c) begin
                spike_d   = 1'b1;
                emitted_d = emitted_q + 1'b1;
            end
            if (slot_idx_q == SLOT_W'(m_q - 1'b1)) begin
                cnt_out_d    = CNT_W'(emitted_d);
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            m_q           <= '0;
            n_q           <= '0;
            slot_idx_q    <= '0;
            emitted_q     <= '0;
            spike         <= 1'b0;
            frame_done    <= 1'b0;
            spike_cnt_out <= '0;
            sat           <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            m_q           <= m_d;
            n_q           <= n_d;
            slot_idx_q    <= slot_idx_d;
            emitted_q     <= emitted_d;
            spike         <= spike_d;
            frame_done    <= frame_done_d;
            spike_cnt_out <= cnt_out_d;
            sat           <= sat_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_spike_train_gen.sv
// Directed self-checking bench for spike_train_gen.
module tb_spike_train_gen;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned SLOT_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              tick;
    logic              frame_start;
    logic [CNT_W-1:0]  i_cnt;
    logic [SLOT_W-1:0] slots;
    logic              spike;
    logic [CNT_W-1:0]  spike_cnt_out;
    logic              frame_done;
    logic              sat;
    logic              busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spike_train_gen #(
        .CNT_W  (CNT_W),
        .SLOT_W (SLOT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .frame_start   (frame_start),
        .i_cnt         (i_cnt),
        .slots         (slots),
        .spike         (spike),
        .spike_cnt_out (spike_cnt_out),
        .frame_done    (frame_done),
        .sat           (sat),
        .busy          (busy)
    );

    // One clock with the given strobes; returns 1 ns after the edge
    task automatic cyc(input logic tk, input logic fs);
        tick        = tk;
        frame_start = fs;
        @(posedge clk);
        #1;
        tick        = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic start_frame(input int s, input int c);
        slots = SLOT_W'(s);
        i_cnt = CNT_W'(c);
        cyc(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        checks++;
        if ({spike, frame_done, sat, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {spike, frame_done, sat, busy});
        end
        checks++;
        if (spike_cnt_out !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", spike_cnt_out);
        end
    endtask

    task automatic test_even();
        logic [3:0] pat;
        logic       done_last;
        pat = '0;
        done_last = 1'b0;
        start_frame(4, 2);
        checks++;
        if ({busy, sat} !== 2'b10) begin
            errors++;
            $display("FAIL even_start: busy,sat got %b want 10", {busy, sat});
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0);
            pat[i] = spike;
            if (i == 3) done_last = frame_done;
        end
        checks++;
        if (pat !== 4'b1010) begin
            errors++;
            $display("FAIL even_pattern: got %b want 1010", pat);
        end
        checks++;
        if (done_last !== 1'b1 || spike_cnt_out !== 32'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL even_done: done=%b cnt=%0d busy=%b want 1 2 0",
                     done_last, spike_cnt_out, busy);
        end
    endtask

    // Idle cycles between ticks also verify the spike is a single-cycle pulse
    task automatic test_sparse();
        logic [9:0] pat;
        int         gap_spikes;
        pat = '0;
        gap_spikes = 0;
        start_frame(10, 3);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0);
            pat[i] = spike;
            cyc(1'b0, 1'b0);
            if (spike) gap_spikes++;
        end
        checks++;
        if (pat !== 10'h248) begin
            errors++;
            $display("FAIL sparse_pattern: got %b want 1001001000", pat);
        end
        checks++;
        if (gap_spikes != 0) begin
            errors++;
            $display("FAIL sparse_gap: got %0d spikes on idle cycles want 0", gap_spikes);
        end
        checks++;
        if (spike_cnt_out !== 32'd3 || sat !== 1'b0) begin
            errors++;
            $display("FAIL sparse_cnt: cnt=%0d sat=%b want 3 0", spike_cnt_out, sat);
        end
    endtask

    task automatic test_sat();
        logic [7:0] pat;
        pat = '0;
        start_frame(8, 20);
        checks++;
        if (sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_flag: got %b want 1", sat);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0);
            pat[i] = spike;
        end
        checks++;
        if (pat !== 8'hFF || spike_cnt_out !== 32'd8 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL sat_frame: pat=%b cnt=%0d done=%b want 11111111 8 1",
                     pat, spike_cnt_out, frame_done);
        end
    endtask

    task automatic test_zero();
        int spikes;
        spikes = 0;
        start_frame(5, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0);
            if (spike) spikes++;
        end
        checks++;
        if (spikes != 0 || frame_done !== 1'b1 || spike_cnt_out !== '0) begin
            errors++;
            $display("FAIL zero_req: spikes=%0d done=%b cnt=%0d want 0 1 0",
                     spikes, frame_done, spike_cnt_out);
        end
    endtask

    task automatic test_abort();
        int first_done;
        int spikes;
        first_done = -1;
        spikes = 0;
        start_frame(10, 10);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        checks++;
        if (spike !== 1'b0 || frame_done !== 1'b1 || spike_cnt_out !== 32'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort: spike=%b done=%b cnt=%0d busy=%b want 0 1 4 1",
                     spike, frame_done, spike_cnt_out, busy);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0);
            if (spike) spikes++;
            if (frame_done && first_done < 0) first_done = i;
        end
        checks++;
        if (first_done != 9 || spikes != 10 || spike_cnt_out !== 32'd10) begin
            errors++;
            $display("FAIL abort_restart: done_idx=%0d spikes=%0d cnt=%0d want 9 10 10",
                     first_done, spikes, spike_cnt_out);
        end
    endtask

    task automatic test_slots_zero();
        start_frame(0, 5);
        checks++;
        if (frame_done !== 1'b1 || spike_cnt_out !== '0 || sat !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL slots_zero: done=%b cnt=%0d sat=%b busy=%b want 1 0 1 0",
                     frame_done, spike_cnt_out, sat, busy);
        end
        cyc(1'b0, 1'b0);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL slots_zero_pulse: done=%b want 0", frame_done);
        end
    endtask

    task automatic test_idle_ticks();
        int spikes;
        spikes = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0);
            if (spike || busy) spikes++;
        end
        checks++;
        if (spikes != 0) begin
            errors++;
            $display("FAIL idle_ticks: got %0d active cycles want 0", spikes);
        end
    endtask

    task automatic test_async_reset();
        int spikes;
        spikes = 0;
        start_frame(10, 10);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({spike, frame_done, sat, busy} !== 4'b0000 || spike_cnt_out !== '0) begin
            errors++;
            $display("FAIL async_reset: flags=%b cnt=%0d want 0000 0",
                     {spike, frame_done, sat, busy}, spike_cnt_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0);
            if (spike) spikes++;
        end
        checks++;
        if (spikes != 0) begin
            errors++;
            $display("FAIL post_reset_idle: got %0d spikes want 0", spikes);
        end
        start_frame(2, 2);
        cyc(1'b1, 1'b0);
        checks++;
        if (spike !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_frame: spike=%b want 1", spike);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        tick        = 1'b0;
        frame_start = 1'b0;
        i_cnt       = '0;
        slots       = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        cyc(1'b0, 1'b0);
        test_idle_ticks();
        test_even();
        test_sparse();
        test_sat();
        test_zero();
        test_slots_zero();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
